// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: stage codes driven onto
// the datapath's estado inputs, the default watchdog limit and a helper that
// tells execution stages apart from the parked states.
package seq_pkg;

    localparam logic [3:0] STAGE_IF    = 4'h0;
    localparam logic [3:0] STAGE_ID    = 4'h1;
    localparam logic [3:0] STAGE_EX    = 4'h2;
    localparam logic [3:0] STAGE_MEM   = 4'h3;
    localparam logic [3:0] STAGE_WB    = 4'h4;
    localparam logic [3:0] STAGE_PCUPD = 4'h8;
    localparam logic [3:0] STAGE_FIM   = 4'h9;
    localparam logic [3:0] STAGE_IDLE  = 4'hA;
    localparam logic [3:0] STAGE_ERR   = 4'hF;

    localparam int DEFAULT_TIMEOUT = 15;

    // The state encoding is the estado code itself, so the state register
    // can drive the datapath directly without a decode step.
    typedef enum logic [3:0] {
        ST_IF    = STAGE_IF,
        ST_ID    = STAGE_ID,
        ST_EX    = STAGE_EX,
        ST_MEM   = STAGE_MEM,
        ST_WB    = STAGE_WB,
        ST_PCUPD = STAGE_PCUPD,
        ST_FIM   = STAGE_FIM,
        ST_IDLE  = STAGE_IDLE,
        ST_ERR   = STAGE_ERR
    } stage_t;

    // True for the stages that wait on stage_done_i.
    function automatic logic is_exec(input stage_t s);
        return s inside {ST_IF, ST_ID, ST_EX, ST_MEM, ST_WB, ST_PCUPD};
    endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage watchdog: counts cycles a stage has waited for its done strobe
// and flags expiry once the count reaches TIMEOUT. The count saturates at the
// limit so it can never wrap back to a harmless value.
module stage_watchdog
    import seq_pkg::*;
#(
    parameter int TO_W    = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

    logic [TO_W-1:0] count;

    // Wait counter: cleared on stage entry, advanced on every stalled cycle.
    // NOTE: sequential state uses non-blocking assignments so every flop in
    // the design samples its inputs at the same edge, independent of the
    // order in which always blocks are evaluated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != LIMIT)) begin
            count <= count + TO_W'(1);
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/instr_sequencer.sv
// Handshake-driven control FSM for the multi-cycle RV32 datapath. Steps each
// instruction through IF, ID, EX, MEM, WB and PC-update, waiting on
// stage_done_i in every stage, with run/step/halt debug control, a per-stage
// watchdog and a retired-instruction counter.
// Build option: define SEQ_SKIP_MEM_EN to add is_mem_i, which lets
// non-memory instructions go straight from EX to WB.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int TO_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             step_i,
    input  logic             halt_req_i,
    input  logic [31:0]      instr_i,
    input  logic             stage_done_i,
`ifdef SEQ_SKIP_MEM_EN
    input  logic             is_mem_i,
`endif
    output logic [3:0]       stage_o,
    output logic             stage_start_o,
    output logic             paused_o,
    output logic             finished_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] retired_o
);

    stage_t state;
    stage_t state_nxt;
    logic   halt_pending;
    logic   single_shot;
    logic   in_exec;
    logic   wd_expired;
    logic   mem_needed;
    logic   stop_at_boundary;

    assign in_exec = is_exec(state);
    assign stage_o = state;

`ifdef SEQ_SKIP_MEM_EN
    assign mem_needed = is_mem_i;
`else
    assign mem_needed = 1'b1;
`endif

    // A halt request arriving in the PCUPD cycle itself still counts for
    // this boundary rather than letting one more instruction slip through.
    assign stop_at_boundary = halt_pending || halt_req_i || single_shot || !run_i;

    // Any advance (done high) or any parked state restarts the wait count,
    // so the count is zero in the entry cycle of every stage.
    stage_watchdog #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (!in_exec || stage_done_i),
        .count_en (in_exec && !stage_done_i),
        .expired  (wd_expired)
    );

    // Next-state selection; done always takes priority over watchdog expiry.
    // NOTE: state_nxt is defaulted before the case so every path assigns it
    // and no latch is inferred for the hold cases.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (run_i || step_i) begin
                    state_nxt = ST_IF;
                end
            end
            ST_FIM, ST_ERR: begin
                state_nxt = state;
            end
            default: begin
                if (stage_done_i) begin
                    case (state)
                        ST_IF:    state_nxt = ST_ID;
                        ST_ID:    state_nxt = (instr_i == 32'd0) ? ST_FIM : ST_EX;
                        ST_EX:    state_nxt = mem_needed ? ST_MEM : ST_WB;
                        ST_MEM:   state_nxt = ST_WB;
                        ST_WB:    state_nxt = ST_PCUPD;
                        ST_PCUPD: state_nxt = stop_at_boundary ? ST_IDLE : ST_IF;
                        default:  state_nxt = state;
                    endcase
                end else if (wd_expired) begin
                    state_nxt = ST_ERR;
                end
            end
        endcase
    end

    // State register, registered status outputs, debug latches and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            stage_start_o <= 1'b0;
            paused_o      <= 1'b1;
            finished_o    <= 1'b0;
            timeout_o     <= 1'b0;
            retired_o     <= '0;
            halt_pending  <= 1'b0;
            single_shot   <= 1'b0;
        end else begin
            state         <= state_nxt;
            stage_start_o <= is_exec(state_nxt) && (state_nxt != state);
            paused_o      <= (state_nxt == ST_IDLE);
            finished_o    <= (state_nxt == ST_FIM);
            timeout_o     <= (state_nxt == ST_ERR);

            if ((state == ST_PCUPD) && stage_done_i) begin
                retired_o <= retired_o + CNT_W'(1);
            end

            if (state_nxt == ST_IDLE) begin
                halt_pending <= 1'b0;
                single_shot  <= 1'b0;
            end else begin
                if (in_exec && halt_req_i) begin
                    halt_pending <= 1'b1;
                end
                // Leaving IDLE: run takes precedence over step.
                if (state == ST_IDLE) begin
                    single_shot <= !run_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer. Each scenario task pushes the
// expected per-cycle outputs onto a scoreboard queue, then pops and compares
// them against the DUT on the falling edge while driving its stimulus.
module tb_instr_sequencer;
    import seq_pkg::*;

    localparam int CNT_W = 2;

    typedef struct packed {
        logic [3:0]       stage;
        logic             start;
        logic             paused;
        logic             finished;
        logic             timeout;
        logic [CNT_W-1:0] retired;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             run_i;
    logic             step_i;
    logic             halt_req_i;
    logic [31:0]      instr_i;
    logic             stage_done_i;
`ifdef SEQ_SKIP_MEM_EN
    logic             is_mem_i;
`endif
    logic [3:0]       stage_o;
    logic             stage_start_o;
    logic             paused_o;
    logic             finished_o;
    logic             timeout_o;
    logic [CNT_W-1:0] retired_o;

    exp_t sb[$];
    exp_t e;
    exp_t o;
    int   errors = 0;
    int   checks = 0;
    int   n;

    logic [3:0] seq6 [6] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8};
    logic [3:0] seq5 [5] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8};

    instr_sequencer #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .run_i         (run_i),
        .step_i        (step_i),
        .halt_req_i    (halt_req_i),
        .instr_i       (instr_i),
        .stage_done_i  (stage_done_i),
`ifdef SEQ_SKIP_MEM_EN
        .is_mem_i      (is_mem_i),
`endif
        .stage_o       (stage_o),
        .stage_start_o (stage_start_o),
        .paused_o      (paused_o),
        .finished_o    (finished_o),
        .timeout_o     (timeout_o),
        .retired_o     (retired_o)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] st, input logic start, input int ret);
        exp_t r;
        r.stage    = st;
        r.start    = start;
        r.paused   = (st == 4'hA);
        r.finished = (st == 4'h9);
        r.timeout  = (st == 4'hF);
        r.retired  = ret[CNT_W-1:0];
        return r;
    endfunction

    function automatic exp_t observe();
        return '{stage_o, stage_start_o, paused_o, finished_o, timeout_o, retired_o};
    endfunction

    // Holds reset for two cycles and releases it on a falling edge.
    task automatic reset_dut();
        rst          = 1'b1;
        run_i        = 1'b0;
        step_i       = 1'b0;
        halt_req_i   = 1'b0;
        stage_done_i = 1'b0;
        instr_i      = 32'h0040_0093;
`ifdef SEQ_SKIP_MEM_EN
        is_mem_i     = 1'b1;
`endif
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; run_i = 1'b0; step_i = 1'b0; halt_req_i = 1'b0;
        stage_done_i = 1'b0; instr_i = 32'h0040_0093;
`ifdef SEQ_SKIP_MEM_EN
        is_mem_i = 1'b1;
`endif
        #1;
        checks++; if (stage_o !== 4'hA) begin errors++; $display("FAIL reset stage: got %h expected a", stage_o); end
        checks++; if (stage_start_o !== 1'b0) begin errors++; $display("FAIL reset start: got %b expected 0", stage_start_o); end
        checks++; if (paused_o !== 1'b1) begin errors++; $display("FAIL reset paused: got %b expected 1", paused_o); end
        checks++; if (finished_o !== 1'b0) begin errors++; $display("FAIL reset finished: got %b expected 0", finished_o); end
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset timeout: got %b expected 0", timeout_o); end
        checks++; if (retired_o !== '0) begin errors++; $display("FAIL reset retired: got %0d expected 0", retired_o); end
        @(negedge clk);
        rst = 1'b0;
        // halt and done are ignored while paused
        halt_req_i = 1'b1; stage_done_i = 1'b1;
        sb.delete();
        for (int k = 1; k <= 3; k++) sb.push_back(mk(4'hA, 1'b0, 0));
        n = sb.size();
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin errors++; $display("FAIL idle_hold k=%0d: got %h expected %h", k, o, e); end
        end
        halt_req_i = 1'b0;
    endtask

    task automatic test_run();
        reset_dut();
        run_i = 1'b1; stage_done_i = 1'b1;
        for (int k = 1; k <= 19; k++) sb.push_back(mk(seq6[(k-1)%6], 1'b1, (k-1)/6));
        n = sb.size();
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin errors++; $display("FAIL run k=%0d: got %h expected %h", k, o, e); end
        end
    endtask

    // Two-cycle stages for four instructions; the 2-bit counter wraps to 0.
    task automatic test_stall_wrap();
        reset_dut();
        run_i = 1'b1;
        for (int k = 1; k <= 49; k++) sb.push_back(mk(seq6[((k-1)/2)%6], k % 2 == 1, (k-1)/12));
        n = sb.size();
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin errors++; $display("FAIL stall_wrap k=%0d: got %h expected %h", k, o, e); end
            stage_done_i = (k % 2 == 0);
        end
    endtask

    task automatic test_step();
        reset_dut();
        stage_done_i = 1'b1; step_i = 1'b1;
        for (int k = 1; k <= 6; k++) sb.push_back(mk(seq6[k-1], 1'b1, 0));
        sb.push_back(mk(4'hA, 1'b0, 1));
        sb.push_back(mk(4'h0, 1'b1, 1));
        n = sb.size();
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin errors++; $display("FAIL step k=%0d: got %h expected %h", k, o, e); end
            // a second step mid-instruction is ignored; run rising mid-step
            // must not extend the single-shot instruction
            step_i = (k == 2);
            if (k == 3) run_i = 1'b1;
        end
    endtask

    task automatic test_halt();
        reset_dut();
        run_i = 1'b1; stage_done_i = 1'b1;
        for (int k = 1; k <= 12; k++) sb.push_back(mk(seq6[(k-1)%6], 1'b1, (k-1)/6));
        sb.push_back(mk(4'hA, 1'b0, 2));
        for (int k = 14; k <= 19; k++) sb.push_back(mk(seq6[k-14], 1'b1, 2));
        sb.push_back(mk(4'h0, 1'b1, 3));
        n = sb.size();
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin errors++; $display("FAIL halt k=%0d: got %h expected %h", k, o, e); end
            halt_req_i = (k == 9);
        end
    endtask

    task automatic test_zero_instr();
        reset_dut();
        run_i = 1'b1; stage_done_i = 1'b1; instr_i = 32'd0;
        sb.push_back(mk(4'h0, 1'b1, 0));
        sb.push_back(mk(4'h1, 1'b1, 0));
        for (int k = 3; k <= 25; k++) sb.push_back(mk(4'h9, 1'b0, 0));
        n = sb.size();
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin errors++; $display("FAIL zero k=%0d: got %h expected %h", k, o, e); end
            step_i = (k == 10);
        end
        step_i = 1'b0;
    endtask

    task automatic test_watchdog();
        // done held low in MEM: 16 cycles in MEM (count 0..15), then ERR
        reset_dut();
        run_i = 1'b1; stage_done_i = 1'b1;
        for (int k = 1; k <= 3; k++) sb.push_back(mk(seq6[k-1], 1'b1, 0));
        for (int k = 4; k <= 19; k++) sb.push_back(mk(4'h3, k == 4, 0));
        for (int k = 20; k <= 24; k++) sb.push_back(mk(4'hF, 1'b0, 0));
        n = sb.size();
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin errors++; $display("FAIL wdog_err k=%0d: got %h expected %h", k, o, e); end
            if (k == 4) stage_done_i = 1'b0;
            if (k == 21) stage_done_i = 1'b1;
        end
        // done arriving in the cycle the count reaches the limit wins
        reset_dut();
        run_i = 1'b1; stage_done_i = 1'b1;
        for (int k = 1; k <= 3; k++) sb.push_back(mk(seq6[k-1], 1'b1, 0));
        for (int k = 4; k <= 19; k++) sb.push_back(mk(4'h3, k == 4, 0));
        sb.push_back(mk(4'h4, 1'b1, 0));
        sb.push_back(mk(4'h8, 1'b1, 0));
        sb.push_back(mk(4'h0, 1'b1, 1));
        n = sb.size();
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin errors++; $display("FAIL wdog_late_done k=%0d: got %h expected %h", k, o, e); end
            if (k == 4) stage_done_i = 1'b0;
            if (k == 19) stage_done_i = 1'b1;
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        run_i = 1'b1; stage_done_i = 1'b1;
        repeat (11) @(negedge clk);
        checks++; if (stage_o !== 4'h4) begin errors++; $display("FAIL arst_pre stage: got %h expected 4", stage_o); end
        checks++; if (retired_o !== 2'd1) begin errors++; $display("FAIL arst_pre retired: got %0d expected 1", retired_o); end
        #2 rst = 1'b1;
        #1;
        checks++; if (stage_o !== 4'hA) begin errors++; $display("FAIL arst stage: got %h expected a", stage_o); end
        checks++; if (retired_o !== 2'd0) begin errors++; $display("FAIL arst retired: got %0d expected 0", retired_o); end
        checks++; if ({stage_start_o, paused_o} !== 2'b01) begin errors++; $display("FAIL arst start/paused: got %b expected 01", {stage_start_o, paused_o}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef SEQ_SKIP_MEM_EN
    task automatic test_skip_mem();
        reset_dut();
        run_i = 1'b1; stage_done_i = 1'b1; is_mem_i = 1'b0;
        for (int k = 1; k <= 11; k++) sb.push_back(mk(seq5[(k-1)%5], 1'b1, (k-1)/5));
        n = sb.size();
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin errors++; $display("FAIL skip_mem k=%0d: got %h expected %h", k, o, e); end
        end
        is_mem_i = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_run();
        test_stall_wrap();
        test_step();
        test_halt();
        test_zero_instr();
        test_watchdog();
        test_async_reset();
`ifdef SEQ_SKIP_MEM_EN
        test_skip_mem();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Handshake-driven control FSM for the multi-cycle RV32 datapath (lw, sw, sub, xor, addi, srl, beq).
- Steps one instruction through IF, ID, EX, MEM, WB and PC-update, waiting on a per-stage done strobe instead of fixed delay states.
- Adds run/step/halt debug control, a per-stage watchdog and a retired-instruction counter.
- Its stage_o drives the existing estado input of every datapath unit.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- TIMEOUT, 15, maximum cycles a stage may wait for stage_done_i (1..2^TO_W-1).
- TO_W, 4, width of the watchdog counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- run_i  input  1  level; free-run while high.
- step_i  input  1  pulse; execute exactly one instruction when paused.
- halt_req_i  input  1  pulse; stop at the next instruction boundary.
- instr_i  input  32  fetched instruction, valid in ID.
- stage_done_i  input  1  current stage has completed.
- stage_o  output  4  current stage code (estado).
- stage_start_o  output  1  one-cycle pulse in the first cycle of each execution stage.
- paused_o  output  1  FSM in IDLE.
- finished_o  output  1  FSM in FIM (zero instruction decoded).
- timeout_o  output  1  FSM in ERR (watchdog expired).
- retired_o  output  CNT_W  count of completed instructions.

Behaviour:
- Stage encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, PCUPD=8, FIM=9, IDLE=4'hA, ERR=4'hF.
- Reset (async): state=IDLE, stage_o=4'hA, stage_start_o=0, paused_o=1, finished_o=0, timeout_o=0, retired_o=0, halt_pending=0, single_shot=0, watchdog=0.
- IDLE:
  - run_i=1 -> IF, single_shot=0.
  - Otherwise step_i=1 -> IF, single_shot=1.
  - halt_req_i and stage_done_i are ignored.
- Execution stages (IF, ID, EX, MEM, WB, PCUPD):
  - stage_start_o=1 in the entry cycle only.
  - stage_done_i is sampled from the entry cycle onward; the FSM advances on the edge where it is high, so minimum stage length is 1 cycle.
  - Order: IF->ID->EX->MEM->WB->PCUPD.
  - ID with done: instr_i==0 -> FIM, else -> EX.
- Watchdog:
  - Cleared on every stage entry; increments each cycle the stage's done is low.
  - When the count reaches TIMEOUT with done still low -> ERR.
  - done in the same cycle the count reaches TIMEOUT advances normally; done wins.
- PCUPD with done:
  - retired_o increments, wrapping modulo 2^CNT_W.
  - Then: halt_pending, single_shot or run_i=0 -> IDLE; else -> IF.
  - halt_pending and single_shot clear on entering IDLE.
- halt_req_i in any execution stage sets halt_pending; it never aborts the current instruction.
- step_i outside IDLE is ignored.
- FIM and ERR are terminal; only rst exits them. stage_start_o stays 0 in both.
- paused_o, finished_o and timeout_o are decoded from registered state (glitch-free, mutually exclusive).
- rst mid-instruction: immediate return to IDLE, counter cleared, no partial retire.

Optional Feature:
- Macro SEQ_SKIP_MEM_EN.
- Defined: adds input is_mem_i (1 bit, valid in EX). On EX done with is_mem_i=0, the FSM goes EX->WB; MEM is not entered and gets no start pulse.
- Undefined: port absent; MEM is always visited.

Decomposition:
- Package seq_pkg: stage-code localparams (IF..ERR), default TIMEOUT.
- Sub-module stage_watchdog: clear input, count-enable input, expired output, parameterised by TO_W and TIMEOUT.
- The FSM, debug latches and retired counter stay in instr_sequencer.

Test Plan:
- Run, single-cycle stages:
  - Stimulus: rst pulse, run_i=1, stage_done_i=1 constantly, nonzero instr_i.
  - Response: stage_o cycles 0,1,2,3,4,8,0…; retired_o=3 after 18 cycles; stage_start_o high every cycle.
- Single step:
  - Stimulus: paused, step_i one cycle, done=1.
  - Response: exactly one instruction (6 stages); retired_o 0->1; returns to IDLE with paused_o=1.
- Halt at boundary:
  - Stimulus: halt_req_i pulse during EX of instruction 2, run_i=1.
  - Response: instruction 2 finishes; IDLE after PCUPD; retired_o=2.
- Zero instruction:
  - Stimulus: instr_i=0 in ID with done.
  - Response: stage_o=9, finished_o=1; stays 9 for 20+ cycles with run_i=1; retired_o unchanged.
- Watchdog:
  - Stimulus: hold stage_done_i=0 in MEM.
  - Response: ERR (stage_o=4'hF, timeout_o=1) after TIMEOUT=15 cycles. Repeat with done raised on cycle 15 -> advances to WB, no error.
- Async reset and wrap:
  - rst asserted mid-WB -> IDLE in the same cycle, retired_o=0.
  - With CNT_W=2, retiring 4 instructions wraps retired_o to 0.
  - With SEQ_SKIP_MEM_EN and is_mem_i=0, stage_o sequence skips 3.
